// File: rtl/speech_pkg.sv
// Shared types and helpers for the speech band classifier.
// Holds the controller state encoding, a constant-foldable clog2, the default
// datapath widths and a saturating adder used by the band accumulators.
package speech_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        DECIDE = 2'd2,
        REPORT = 2'd3
    } state_t;

    localparam int DW_DEF    = 38;
    localparam int ACC_W_DEF = 48;

    // Working width of the saturating adder; accumulators up to 64 bits wide.
    localparam int SAT_W     = 64;

    // Ceiling log2, usable in parameter and port-width expressions.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Unsigned a + b, clamped to 2^width - 1 (width <= SAT_W).
    function automatic logic [SAT_W-1:0] sat_add(input logic [SAT_W-1:0] a,
                                                 input logic [SAT_W-1:0] b,
                                                 input int               width);
        logic [SAT_W:0] sum;
        logic [SAT_W:0] lim;
        sum = {1'b0, a} + {1'b0, b};
        lim = (65'd1 << width) - 65'd1;
        if (sum > lim) begin
            return lim[SAT_W-1:0];
        end else begin
            return sum[SAT_W-1:0];
        end
    endfunction

endpackage

// File: rtl/speech_mag_unit.sv
// Bin magnitude unit for the speech band classifier.
// Default build: combinational |re| + |im|, where |most negative| clamps to the
// largest positive value. With SPEECH_SQMAG_EN defined: re*re + im*im, held in
// one pipeline register (adds clk/rst ports). Either result is saturated into
// the accumulator width. A tag travels alongside so the caller keeps the band
// index aligned with the magnitude.
module speech_mag_unit
    import speech_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int ACC_W = ACC_W_DEF,
    parameter int TAG_W = 1
) (
`ifdef SPEECH_SQMAG_EN
    input  logic                    clk,
    input  logic                    rst,
`endif
    input  logic                    in_valid,
    input  logic [TAG_W-1:0]        in_tag,
    input  logic signed [DW-1:0]    re,
    input  logic signed [DW-1:0]    im,
    output logic                    out_valid,
    output logic [TAG_W-1:0]        out_tag,
    output logic [ACC_W-1:0]        mag
);

    // Common width wide enough for either magnitude form and the clamp value.
    localparam int CW = ((ACC_W > 2 * DW) ? ACC_W : 2 * DW) + 1;
    localparam logic [ACC_W-1:0] ACC_MAX = {ACC_W{1'b1}};

    // Clamp a wide unsigned value into the accumulator width.
    function automatic logic [ACC_W-1:0] sat_to_acc(input logic [CW-1:0] v);
        if (v > CW'(ACC_MAX)) begin
            return ACC_MAX;
        end else begin
            return v[ACC_W-1:0];
        end
    endfunction

`ifdef SPEECH_SQMAG_EN

    logic signed [2*DW-1:0] prod_re_s;
    logic signed [2*DW-1:0] prod_im_s;
    logic [2*DW:0]          sq_sum_s;

    // Squares are never negative, so the sum is treated as unsigned.
    always_comb begin
        prod_re_s = re * re;
        prod_im_s = im * im;
        sq_sum_s  = {1'b0, prod_re_s} + {1'b0, prod_im_s};
    end

    // Pipeline register: magnitude, valid and tag advance together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            out_tag   <= {TAG_W{1'b0}};
            mag       <= {ACC_W{1'b0}};
        end else begin
            out_valid <= in_valid;
            out_tag   <= in_tag;
            mag       <= sat_to_acc(CW'(sq_sum_s));
        end
    end

`else

    localparam logic signed [DW-1:0] MOST_NEG = {1'b1, {(DW-1){1'b0}}};
    localparam logic [DW-1:0]        MAX_POS  = {1'b0, {(DW-1){1'b1}}};

    // Absolute value; the most negative input has no positive twin and clamps.
    function automatic logic [DW-1:0] abs_sat(input logic signed [DW-1:0] x);
        if (x == MOST_NEG) begin
            return MAX_POS;
        end else if (x[DW-1]) begin
            return -x;
        end else begin
            return x;
        end
    endfunction

    logic [DW:0] l1_sum_s;

    // L1 magnitude at DW+1 bits, then clamp into the accumulator width.
    always_comb begin
        l1_sum_s  = {1'b0, abs_sat(re)} + {1'b0, abs_sat(im)};
        out_valid = in_valid;
        out_tag   = in_tag;
        mag       = sat_to_acc(CW'(l1_sum_s));
    end

`endif

endmodule

// File: rtl/speech_band_classifier.sv
// Speech band classifier: accumulates per-band bin magnitudes over NUM_FRAMES
// FFT frames, then picks the most energetic band (lowest index wins ties) as an
// N-class one-hot word result, or flags no_word when the winner is under THRESH.
// Optional build macro SPEECH_SQMAG_EN switches to squared magnitude, which adds
// one pipeline stage and therefore one cycle of result latency.
module speech_band_classifier
    import speech_pkg::*;
#(
    parameter int DW            = DW_DEF,
    parameter int FFT_LEN       = 64,
    parameter int NUM_BANDS     = 4,
    parameter int BINS_PER_BAND = 8,
    parameter int NUM_FRAMES    = 4,
    parameter int ACC_W         = ACC_W_DEF,
    parameter int THRESH        = 1000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          fft_valid,
    input  logic signed [DW-1:0]          re,
    input  logic signed [DW-1:0]          im,
    output logic                          busy,
    output logic                          result_valid,
    output logic [NUM_BANDS-1:0]          class_onehot,
    output logic [clog2(NUM_BANDS)-1:0]   class_idx,
    output logic                          no_word
);

    localparam int IDX_W = clog2(NUM_BANDS);
    localparam int BIN_W = (clog2(FFT_LEN) > 0) ? clog2(FFT_LEN) : 1;
    localparam int FRM_W = (clog2(NUM_FRAMES) > 0) ? clog2(NUM_FRAMES) : 1;

    state_t              state_r;
    state_t              state_nxt_s;

    logic [BIN_W-1:0]    bin_cnt_r;
    logic [FRM_W-1:0]    frame_cnt_r;
    logic [ACC_W-1:0]    acc_r [NUM_BANDS];

    logic [IDX_W-1:0]    decide_idx_r;
    logic [IDX_W-1:0]    best_idx_r;
    logic [ACC_W-1:0]    best_val_r;

    logic                start_acc_s;
    logic                bin_take_s;
    logic                last_bin_s;
    logic [31:0]         bin_ext_s;
    logic [IDX_W-1:0]    band_s;
    logic                in_range_s;

    logic                acc_en_s;
    logic [IDX_W-1:0]    acc_band_s;
    logic [ACC_W-1:0]    mag_s;

`ifdef SPEECH_SQMAG_EN
    // Set for the one cycle after the final bin while its magnitude drains.
    logic                drain_r;
`endif

    // Handshake decode: accepted start, accepted bin, and the final bin.
    always_comb begin
        start_acc_s = (state_r == IDLE) && start;
`ifdef SPEECH_SQMAG_EN
        bin_take_s  = (state_r == ACCUM) && fft_valid && !drain_r;
`else
        bin_take_s  = (state_r == ACCUM) && fft_valid;
`endif
        last_bin_s  = bin_take_s &&
                      (bin_cnt_r == BIN_W'(FFT_LEN - 1)) &&
                      (frame_cnt_r == FRM_W'(NUM_FRAMES - 1));
    end

    // Map the current bin to its band; bins past the last band are out of range.
    always_comb begin
        bin_ext_s  = 32'(bin_cnt_r);
        band_s     = {IDX_W{1'b0}};
        in_range_s = 1'b0;
        for (int b = 0; b < NUM_BANDS; b++) begin
            if ((bin_ext_s >= 32'(b * BINS_PER_BAND)) &&
                (bin_ext_s < 32'((b + 1) * BINS_PER_BAND))) begin
                band_s     = IDX_W'(b);
                in_range_s = 1'b1;
            end else begin
                band_s     = band_s;
                in_range_s = in_range_s;
            end
        end
    end

    speech_mag_unit #(
        .DW    (DW),
        .ACC_W (ACC_W),
        .TAG_W (IDX_W)
    ) u_mag (
`ifdef SPEECH_SQMAG_EN
        .clk       (clk),
        .rst       (rst),
`endif
        .in_valid  (bin_take_s && in_range_s),
        .in_tag    (band_s),
        .re        (re),
        .im        (im),
        .out_valid (acc_en_s),
        .out_tag   (acc_band_s),
        .mag       (mag_s)
    );

    // Controller state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic: capture, scan bands one per cycle, report once.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_nxt_s = ACCUM;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ACCUM: begin
`ifdef SPEECH_SQMAG_EN
                if (drain_r) begin
                    state_nxt_s = DECIDE;
                end else begin
                    state_nxt_s = ACCUM;
                end
`else
                if (last_bin_s) begin
                    state_nxt_s = DECIDE;
                end else begin
                    state_nxt_s = ACCUM;
                end
`endif
            end
            DECIDE: begin
                if (decide_idx_r == IDX_W'(NUM_BANDS - 1)) begin
                    state_nxt_s = REPORT;
                end else begin
                    state_nxt_s = DECIDE;
                end
            end
            REPORT: begin
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Bin/frame counters; they only move on accepted bins.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bin_cnt_r   <= {BIN_W{1'b0}};
            frame_cnt_r <= {FRM_W{1'b0}};
        end else if (start_acc_s) begin
            bin_cnt_r   <= {BIN_W{1'b0}};
            frame_cnt_r <= {FRM_W{1'b0}};
        end else if (bin_take_s) begin
            if (bin_cnt_r == BIN_W'(FFT_LEN - 1)) begin
                bin_cnt_r   <= {BIN_W{1'b0}};
                frame_cnt_r <= frame_cnt_r + FRM_W'(1);
            end else begin
                bin_cnt_r   <= bin_cnt_r + BIN_W'(1);
            end
        end
    end

`ifdef SPEECH_SQMAG_EN
    // Hold ACCUM one extra cycle so the final pipelined magnitude lands.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drain_r <= 1'b0;
        end else begin
            drain_r <= last_bin_s;
        end
    end
`endif

    // Band accumulators: cleared on an accepted start, saturating otherwise.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_BANDS; i++) begin
                acc_r[i] <= {ACC_W{1'b0}};
            end
        end else if (start_acc_s) begin
            for (int i = 0; i < NUM_BANDS; i++) begin
                acc_r[i] <= {ACC_W{1'b0}};
            end
        end else if (acc_en_s) begin
            acc_r[acc_band_s] <= ACC_W'(sat_add(SAT_W'(acc_r[acc_band_s]),
                                                SAT_W'(mag_s), ACC_W));
        end
    end

    // Sequential argmax: band 0 seeds the best, later bands must be strictly larger.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            decide_idx_r <= {IDX_W{1'b0}};
            best_idx_r   <= {IDX_W{1'b0}};
            best_val_r   <= {ACC_W{1'b0}};
        end else if (state_r == DECIDE) begin
            if ((decide_idx_r == {IDX_W{1'b0}}) || (acc_r[decide_idx_r] > best_val_r)) begin
                best_val_r <= acc_r[decide_idx_r];
                best_idx_r <= decide_idx_r;
            end
            decide_idx_r <= decide_idx_r + IDX_W'(1);
        end else begin
            decide_idx_r <= {IDX_W{1'b0}};
        end
    end

    // Registered outputs: busy spans the capture, results load once in REPORT.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy         <= 1'b0;
            result_valid <= 1'b0;
            class_onehot <= {NUM_BANDS{1'b0}};
            class_idx    <= {IDX_W{1'b0}};
            no_word      <= 1'b0;
        end else if (state_r == REPORT) begin
            busy         <= 1'b0;
            result_valid <= 1'b1;
            if (best_val_r < ACC_W'(THRESH)) begin
                no_word      <= 1'b1;
                class_onehot <= {NUM_BANDS{1'b0}};
                class_idx    <= {IDX_W{1'b0}};
            end else begin
                no_word      <= 1'b0;
                class_onehot <= NUM_BANDS'(1) << best_idx_r;
                class_idx    <= best_idx_r;
            end
        end else begin
            result_valid <= 1'b0;
            if (start_acc_s) begin
                busy <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_speech_band_classifier.sv
// Scoreboard bench for speech_band_classifier (DW=38, FFT_LEN=8, 2 bands of 4
// bins, 1 frame, THRESH=100). Stimulus pushes the hand-computed result and the
// cycle at which it must appear; a monitor pops and compares on result_valid.
module tb_speech_band_classifier;

    localparam int DW = 38;
    localparam int FL = 8;

    logic                   clk = 1'b0;
    logic                   rst = 1'b0;
    logic                   start = 1'b0;
    logic                   fft_valid = 1'b0;
    logic signed [DW-1:0]   re = '0;
    logic signed [DW-1:0]   im = '0;
    logic                   busy;
    logic                   result_valid;
    logic [1:0]             class_onehot;
    logic [0:0]             class_idx;
    logic                   no_word;

    typedef struct {
        logic [0:0] idx;
        logic [1:0] oh;
        logic       nw;
        int         cyc;
    } exp_t;

    exp_t                   sb_q[$];
    int                     total = 0;
    int                     bad = 0;
    int                     cyc = 0;
    logic signed [DW-1:0]   re_tab [FL];
    logic signed [DW-1:0]   im_tab [FL];
    logic signed [DW-1:0]   max_pos;
    logic signed [DW-1:0]   most_neg;

    speech_band_classifier #(
        .DW            (DW),
        .FFT_LEN       (FL),
        .NUM_BANDS     (2),
        .BINS_PER_BAND (4),
        .NUM_FRAMES    (1),
        .ACC_W         (48),
        .THRESH        (100)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .fft_valid    (fft_valid),
        .re           (re),
        .im           (im),
        .busy         (busy),
        .result_valid (result_valid),
        .class_onehot (class_onehot),
        .class_idx    (class_idx),
        .no_word      (no_word)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Monitor: every result pulse must match the oldest pending expectation.
    always @(posedge clk) begin : monitor
        exp_t e;
        #1;
        if (result_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_result cyc=%0d actual=1 required=0", cyc);
            end else begin
                e = sb_q.pop_front();
                check("class_idx", 64'(class_idx), 64'(e.idx));
                check("class_onehot", 64'(class_onehot), 64'(e.oh));
                check("no_word", 64'(no_word), 64'(e.nw));
                check("latency_cycle", 64'(cyc), 64'(e.cyc));
                check("busy_at_result", 64'(busy), 64'd0);
            end
        end
    end

    // One utterance: start pulse, 8 bins from the tables, then queue the expectation.
    task automatic run_word(input bit gaps, input bit stray_start,
                            input logic [0:0] eidx, input logic [1:0] eoh, input logic enw);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        fft_valid = 1'b0;
        for (int i = 0; i < FL; i++) begin
            if (gaps && (i % 2 == 1)) begin
                fft_valid = 1'b0;
                re = 38'sd777;
                @(posedge clk); #1;
            end
            fft_valid = 1'b1;
            re = re_tab[i];
            im = im_tab[i];
            if (stray_start && i == 5) start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
        end
        fft_valid = 1'b0;
        re = '0;
        im = '0;
        sb_q.push_back('{eidx, eoh, enw, cyc + 3});
        repeat (6) @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        max_pos  = {1'b0, {(DW-1){1'b1}}};
        most_neg = {1'b1, {(DW-1){1'b0}}};

        // Reset and idle outputs.
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_result_valid", 64'(result_valid), 64'd0);
        check("reset_onehot", 64'(class_onehot), 64'd0);
        check("reset_idx", 64'(class_idx), 64'd0);
        check("reset_no_word", 64'(no_word), 64'd0);

        // Abort a capture with reset: busy must drop at once, no result follows.
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_after_start", 64'(busy), 64'd1);
        for (int i = 0; i < 3; i++) begin
            fft_valid = 1'b1;
            re = 38'sd500;
            @(posedge clk); #1;
        end
        fft_valid = 1'b0;
        #2 rst = 1'b0;
        #1 check("busy_async_reset", 64'(busy), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        repeat (10) @(posedge clk);
        #1;

        // Low-band word: acc0=240, acc1=20.
        for (int i = 0; i < FL; i++) begin
            re_tab[i] = (i < 4) ? 38'sd50 : 38'sd5;
            im_tab[i] = (i < 4) ? -38'sd10 : 38'sd0;
        end
        run_word(1'b0, 1'b0, 1'b0, 2'b01, 1'b0);

        // High-band word with fft_valid gaps: acc0=4, acc1=160.
        for (int i = 0; i < FL; i++) begin
            re_tab[i] = (i < 4) ? 38'sd1 : 38'sd0;
            im_tab[i] = (i < 4) ? 38'sd0 : 38'sd40;
        end
        run_word(1'b1, 1'b0, 1'b1, 2'b10, 1'b0);

        // Silence (24/24 < 100), preceded by stray bins in IDLE and on the start cycle.
        for (int i = 0; i < FL; i++) begin
            re_tab[i] = 38'sd3;
            im_tab[i] = 38'sd3;
        end
        fft_valid = 1'b1;
        re = 38'sd1000;
        im = 38'sd0;
        repeat (3) @(posedge clk);
        #1;
        run_word(1'b0, 1'b0, 1'b0, 2'b00, 1'b1);

        // Tie at 120 with a stray start mid-capture: lowest index wins.
        for (int i = 0; i < FL; i++) begin
            re_tab[i] = 38'sd30;
            im_tab[i] = 38'sd0;
        end
        run_word(1'b0, 1'b1, 1'b0, 2'b01, 1'b0);

        // |most negative| clamps to 2^37-1, tying with band 0 -> band 0.
        for (int i = 0; i < FL; i++) begin
            re_tab[i] = 38'sd0;
            im_tab[i] = 38'sd0;
        end
        re_tab[0] = max_pos;
        re_tab[4] = most_neg;
        run_word(1'b0, 1'b0, 1'b0, 2'b01, 1'b0);

        // Drain any outstanding expectation within a bounded wait.
        for (int i = 0; i < 50 && sb_q.size() != 0; i++) begin
            @(posedge clk);
        end
        #2;
        check("pending_results", 64'(sb_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/speech_band_classifier.md
Name: speech_band_classifier

Overview:
- Parametrised successor to the two-word speech classifier: consumes streamed complex FFT bins and accumulates per-band magnitude energy over NUM_FRAMES frames.
- Selects the dominant band as the recognised word class, replacing the fixed alpha/zulu outputs with an N-class one-hot result.
- Sits directly after the FFT core; its result feeds the display/control logic.

Parameters:
- DW, 38, signed width of re/im bin inputs
- FFT_LEN, 64, valid bins per frame
- NUM_BANDS, 4, word classes (bands), >=2
- BINS_PER_BAND, 8, bins per band; bins at index >= NUM_BANDS*BINS_PER_BAND are ignored
- NUM_FRAMES, 4, frames accumulated per utterance, >=1
- ACC_W, 48, band accumulator width (saturating)
- THRESH, 1000, minimum winning energy; below it the result is no_word

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse that begins an utterance capture
- fft_valid  in  1  re/im hold a valid bin this cycle
- re  in  DW  signed real part
- im  in  DW  signed imaginary part
- busy  out  1  high from the accepted start until result_valid
- result_valid  out  1  one-cycle pulse, result fields valid
- class_onehot  out  NUM_BANDS  one-hot winning band; zero when no_word
- class_idx  out  clog2(NUM_BANDS)  winning band index; 0 when no_word
- no_word  out  1  winning energy < THRESH

Behaviour:
- Reset (rst low, asynchronous): state IDLE; all accumulators and counters 0; all outputs 0. Result outputs hold their values until the next result_valid or reset.
- States: IDLE -> ACCUM -> DECIDE -> REPORT -> IDLE.
- IDLE:
  - start=1 clears all accumulators, bin_cnt and frame_cnt; next state ACCUM; busy=1 from the next cycle.
  - fft_valid is ignored in IDLE.
- ACCUM:
  - Each fft_valid cycle: mag = |re| + |im|, computed at DW+1 bits.
  - |x| of the most negative value saturates to 2^(DW-1)-1.
  - band = bin_cnt / BINS_PER_BAND. When band < NUM_BANDS, acc[band] += mag, saturating at 2^ACC_W-1.
  - bin_cnt wraps at FFT_LEN-1 -> 0 and increments frame_cnt.
  - When the last bin of frame NUM_FRAMES-1 is accepted, next state is DECIDE.
  - fft_valid low stalls the counters; there is no timeout.
- DECIDE: sequential argmax, one band per cycle, indices 0..NUM_BANDS-1; takes exactly NUM_BANDS cycles.
  - A band replaces the current best only if strictly greater, so the lowest index wins ties.
- REPORT (1 cycle):
  - result_valid=1; class_idx/class_onehot load the winner.
  - If best < THRESH: no_word=1, class_onehot=0, class_idx=0.
  - busy drops in the same cycle; next state IDLE.
- Latency: result_valid asserts NUM_BANDS+1 cycles after the clock edge that accepts the final bin.
- start while busy: ignored; the capture in progress is unaffected.
- start and fft_valid in the same IDLE cycle: that bin is not counted.
- Reset mid-operation: returns to IDLE immediately with no result_valid; the partial capture is discarded.

Optional Feature:
- SPEECH_SQMAG_EN
  - Defined: mag = re*re + im*im, at 2*DW bits, saturated into ACC_W. Adds one pipeline register, so result_valid latency after the final bin becomes NUM_BANDS+2 cycles.
  - Undefined: |re| + |im| as specified above.

Decomposition:
- Package speech_pkg holds:
  - state enum (IDLE/ACCUM/DECIDE/REPORT)
  - clog2 helper function
  - default DW/ACC_W constants
  - saturating-add function
- One sub-module: speech_mag_unit, combinational |re|+|im| with saturation; registered squared magnitude under SPEECH_SQMAG_EN.

Test Plan (DW=38, FFT_LEN=8, NUM_BANDS=2, BINS_PER_BAND=4, NUM_FRAMES=1, THRESH=100):
- Reset: hold rst low, then release; all outputs 0, busy 0. Pulse start, feed 3 bins, pull rst low; busy drops asynchronously and no result_valid ever follows.
- Low-band word: bins 0-3 with re=50, im=-10, bins 4-7 with re=5, im=0.
  - Expected: acc0=240, acc1=20.
  - Expected result: class_idx=0, onehot=01, no_word=0, result_valid 3 cycles after the last bin.
- High-band word with fft_valid gaps: bins 4-7 re=0, im=40, low bins 1; expect class_idx=1, onehot=10.
- Silence and tie:
  - All bins re=im=3: both acc=24 -> no_word=1, onehot=00.
  - All bins re=30: tie at 120 -> class_idx=0.
- Saturation and stray inputs:
  - re=-2^37: mag saturates to 2^37-1.
  - start pulsed during ACCUM: ignored.
  - fft_valid asserted in IDLE: accumulates nothing.
